// File: rtl/branch_predictor_if.sv
// Resolution (training) bus from the resolving stage into the predictor.
// master: resolving stage drives; slave: branch_predictor receives.
interface branch_predictor_if #(
    parameter int PC_W = 16
);
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_is_ctrl;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            upd_mispredict;

    modport master (
        output upd_valid,
        output upd_pc,
        output upd_is_ctrl,
        output upd_taken,
        output upd_target,
        output upd_mispredict
    );

    modport slave (
        input upd_valid,
        input upd_pc,
        input upd_is_ctrl,
        input upd_taken,
        input upd_target,
        input upd_mispredict
    );
endinterface

// File: rtl/branch_predictor.sv
// IF-stage next-PC predictor: direct-mapped BTB with 2-bit counters.
// Ports: clk, reset (sync, active-high); pc -> pred_next_pc/pred_taken
// (combinational); upd (slave) trains the BTB; stat_* perf counters.
module branch_predictor #(
    parameter int         PC_W     = 16,
    parameter int         IDX_W    = 4,
    parameter logic [1:0] CNT_INIT = 2'b10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pred_next_pc,
    output logic            pred_taken,
    branch_predictor_if.slave upd,
    output logic [15:0]     stat_lookups,
    output logic [15:0]     stat_mispredicts
);
    localparam int ENT   = 2**IDX_W;
    localparam int TAG_W = PC_W - IDX_W;

    logic             r_valid  [ENT];
    logic [TAG_W-1:0] r_tag    [ENT];
    logic [PC_W-1:0]  r_target [ENT];
    logic [1:0]       r_cnt    [ENT];
    logic [15:0]      r_lookups;
    logic [15:0]      r_mispredicts;

    logic [IDX_W-1:0] w_idx;
    logic             w_hit;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;
    logic             w_do_upd;

    // Lookup reads the registered state only, so a same-cycle update
    // to the same index is seen from the next cycle on.
    assign w_idx        = pc[IDX_W-1:0];
    assign w_hit        = r_valid[w_idx] && (r_tag[w_idx] == pc[PC_W-1:IDX_W]);
    assign pred_taken   = w_hit && r_cnt[w_idx][1];
    assign pred_next_pc = pred_taken ? r_target[w_idx] : pc + 1'b1;

    assign w_uidx   = upd.upd_pc[IDX_W-1:0];
    assign w_utag   = upd.upd_pc[PC_W-1:IDX_W];
    assign w_uhit   = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_do_upd = upd.upd_valid && upd.upd_is_ctrl;

    // Tag/target are left alone by reset; valid=0 masks them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENT; i++) begin
                r_valid[i] <= 1'b0;
                r_cnt[i]   <= 2'b00;
            end
        end else if (w_do_upd) begin
            if (w_uhit) begin
                if (upd.upd_taken) begin
                    if (r_cnt[w_uidx] != 2'b11)
                        r_cnt[w_uidx] <= r_cnt[w_uidx] + 2'b01;
                    r_target[w_uidx] <= upd.upd_target;
                end else if (r_cnt[w_uidx] != 2'b00) begin
                    r_cnt[w_uidx] <= r_cnt[w_uidx] - 2'b01;
                end
            end else if (upd.upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= upd.upd_target;
                r_cnt[w_uidx]    <= CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lookups     <= 16'h0000;
            r_mispredicts <= 16'h0000;
        end else if (w_do_upd) begin
            if (r_lookups != 16'hFFFF)
                r_lookups <= r_lookups + 16'h0001;
            if (upd.upd_mispredict && r_mispredicts != 16'hFFFF)
                r_mispredicts <= r_mispredicts + 16'h0001;
        end
    end

    assign stat_lookups     = r_lookups;
    assign stat_mispredicts = r_mispredicts;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed training/lookup vectors.
// Stimulus pushes expected outputs; a negedge monitor pops and compares.
module tb_branch_predictor;
    logic        clk;
    logic        reset;
    logic [15:0] pc;
    logic [15:0] pred_next_pc;
    logic        pred_taken;
    logic [15:0] stat_lookups;
    logic [15:0] stat_mispredicts;

    branch_predictor_if #(.PC_W(16)) bus ();

    branch_predictor #(.PC_W(16), .IDX_W(4), .CNT_INIT(2'b10)) dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .pred_next_pc     (pred_next_pc),
        .pred_taken       (pred_taken),
        .upd              (bus.slave),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] nxt;
        logic        tk;
        logic [15:0] lk;
        logic [15:0] mp;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (pred_next_pc !== e.nxt || pred_taken !== e.tk ||
                stat_lookups !== e.lk || stat_mispredicts !== e.mp) begin
                failures++;
                $display("FAIL %s: got nxt=%h tk=%b lk=%0d mp=%0d want nxt=%h tk=%b lk=%0d mp=%0d",
                         e.name, pred_next_pc, pred_taken, stat_lookups,
                         stat_mispredicts, e.nxt, e.tk, e.lk, e.mp);
            end
        end
    end

    // One cycle: drive inputs, push the expected outputs for this cycle.
    task automatic cyc(input string nm, input logic rst, input logic [15:0] p,
                       input logic uv, input logic ic, input logic utk,
                       input logic [15:0] upc, input logic [15:0] tgt,
                       input logic mpr, input logic [15:0] enxt,
                       input logic etk, input logic [15:0] elk,
                       input logic [15:0] emp);
        exp_t e;
        reset              = rst;
        pc                 = p;
        bus.upd_valid      = uv;
        bus.upd_is_ctrl    = ic;
        bus.upd_taken      = utk;
        bus.upd_pc         = upc;
        bus.upd_target     = tgt;
        bus.upd_mispredict = mpr;
        e.name = nm; e.nxt = enxt; e.tk = etk; e.lk = elk; e.mp = emp;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic [15:0] p,
                        input logic [15:0] enxt, input logic etk,
                        input logic [15:0] elk, input logic [15:0] emp);
        cyc(nm, 1'b0, p, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0,
            enxt, etk, elk, emp);
    endtask

    task automatic upd(input string nm, input logic [15:0] p,
                       input logic [15:0] upc, input logic utk,
                       input logic [15:0] tgt, input logic mpr,
                       input logic [15:0] enxt, input logic etk,
                       input logic [15:0] elk, input logic [15:0] emp);
        cyc(nm, 1'b0, p, 1'b1, 1'b1, utk, upc, tgt, mpr,
            enxt, etk, elk, emp);
    endtask

    initial begin
        reset = 1'b1; pc = 16'h0;
        bus.upd_valid = 1'b0; bus.upd_is_ctrl = 1'b0; bus.upd_taken = 1'b0;
        bus.upd_pc = 16'h0; bus.upd_target = 16'h0; bus.upd_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        idle("reset_state",      16'h0010, 16'h0011, 1'b0, 16'd0, 16'd0);
        upd ("first_alloc_old",  16'h0010, 16'h0010, 1'b1, 16'h0040, 1'b1,
             16'h0011, 1'b0, 16'd0, 16'd0);
        upd ("hit_cnt2",         16'h0010, 16'h0010, 1'b1, 16'h0040, 1'b0,
             16'h0040, 1'b1, 16'd1, 16'd1);
        upd ("hit_cnt3",         16'h0010, 16'h0010, 1'b1, 16'h0040, 1'b0,
             16'h0040, 1'b1, 16'd2, 16'd1);
        upd ("sat_cnt3",         16'h0010, 16'h0010, 1'b0, 16'h0000, 1'b1,
             16'h0040, 1'b1, 16'd3, 16'd1);
        upd ("cnt2_taken",       16'h0010, 16'h0010, 1'b0, 16'h0000, 1'b1,
             16'h0040, 1'b1, 16'd4, 16'd2);
        upd ("cnt1_not_taken",   16'h0010, 16'h0010, 1'b0, 16'h0000, 1'b0,
             16'h0011, 1'b0, 16'd5, 16'd3);
        upd ("cnt0",             16'h0010, 16'h0010, 1'b0, 16'h0000, 1'b0,
             16'h0011, 1'b0, 16'd6, 16'd3);
        upd ("cnt0_hold",        16'h0010, 16'h0010, 1'b0, 16'h0000, 1'b0,
             16'h0011, 1'b0, 16'd7, 16'd3);
        cyc ("non_ctrl", 1'b0,   16'h0010, 1'b1, 1'b0, 1'b1, 16'h0010,
             16'h0200, 1'b1, 16'h0011, 1'b0, 16'd8, 16'd3);
        upd ("cnt0_to_1",        16'h0010, 16'h0010, 1'b1, 16'h0050, 1'b1,
             16'h0011, 1'b0, 16'd8, 16'd3);
        idle("valid_at_cnt1",    16'h0010, 16'h0011, 1'b0, 16'd9, 16'd4);
        upd ("alias_lookup",     16'h0020, 16'h0010, 1'b1, 16'h0050, 1'b0,
             16'h0021, 1'b0, 16'd9, 16'd4);
        idle("alias_miss",       16'h0020, 16'h0021, 1'b0, 16'd10, 16'd4);
        idle("own_tag_hit",      16'h0010, 16'h0050, 1'b1, 16'd10, 16'd4);
        upd ("replace_old",      16'h0020, 16'h0020, 1'b1, 16'h0100, 1'b1,
             16'h0021, 1'b0, 16'd10, 16'd4);
        idle("replaced_hit",     16'h0020, 16'h0100, 1'b1, 16'd11, 16'd5);
        idle("evicted_miss",     16'h0010, 16'h0011, 1'b0, 16'd11, 16'd5);
        upd ("same_cycle_old",   16'h0030, 16'h0030, 1'b1, 16'h0300, 1'b1,
             16'h0031, 1'b0, 16'd11, 16'd5);
        idle("same_cycle_new",   16'h0030, 16'h0300, 1'b1, 16'd12, 16'd6);
        idle("wrap",             16'hFFFF, 16'h0000, 1'b0, 16'd12, 16'd6);
        upd ("idx5_old",         16'h0035, 16'h0035, 1'b1, 16'h0777, 1'b0,
             16'h0036, 1'b0, 16'd12, 16'd6);
        idle("idx5_hit",         16'h0035, 16'h0777, 1'b1, 16'd13, 16'd6);
        idle("idx0_untouched",   16'h0030, 16'h0300, 1'b1, 16'd13, 16'd6);
        cyc ("rst_with_upd", 1'b1, 16'h0045, 1'b1, 1'b1, 1'b1, 16'h0045,
             16'h0555, 1'b1, 16'h0046, 1'b0, 16'd13, 16'd6);
        idle("rst_no_alloc",     16'h0045, 16'h0046, 1'b0, 16'd0, 16'd0);
        idle("rst_clr_idx0",     16'h0030, 16'h0031, 1'b0, 16'd0, 16'd0);
        idle("rst_clr_idx5",     16'h0035, 16'h0036, 1'b0, 16'd0, 16'd0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- IF-stage next-PC predictor for the pipelined 16-bit CPU.
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters per entry.
- Supplies the predicted next PC every cycle.
- Trained by branch/jump resolution from later stages. Those stages compute the misprediction flags that feed the control unit's flush logic.

Parameters:
- PC_W, 16, width of PC, targets and tags.
- IDX_W, 4, BTB index bits; entries = 2**IDX_W.
- CNT_INIT, 2'b10, counter value written when a new entry is allocated (weakly taken).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high; clears all BTB state and perf counters.
- pc  in  PC_W  current IF-stage PC.
- pred_next_pc  out  PC_W  predicted next PC, combinational from pc and state.
- pred_taken  out  1  1 when the prediction came from a BTB hit with counter >= 2.
- upd_valid  in  1  resolution event this cycle; a single-cycle pulse per resolved instruction.
- upd_pc  in  PC_W  PC of the resolved branch/jump.
- upd_is_ctrl  in  1  resolved instruction is a branch or jump (IsBranch | IsJump).
- upd_taken  in  1  actual outcome (jumps always 1).
- upd_target  in  PC_W  actual taken target.
- upd_mispredict  in  1  resolving stage detected a misprediction for this instruction.
- stat_lookups  out  16  count of resolved control instructions, saturating at 16'hFFFF.
- stat_mispredicts  out  16  count of resolved mispredictions, saturating at 16'hFFFF.

Behaviour:
- Storage per entry: valid (1), tag (PC_W-IDX_W, = pc[PC_W-1:IDX_W]), target (PC_W), cnt (2).
- Lookup (combinational, no state change):
  - idx = pc[IDX_W-1:0].
  - hit = valid[idx] & tag[idx]==pc[PC_W-1:IDX_W].
  - pred_taken = hit & cnt[idx][1].
  - pred_next_pc = pred_taken ? target[idx] : pc+1, with the 16-bit add wrapping (16'hFFFF+1 = 0).
- Update (registered, on clk when upd_valid & upd_is_ctrl & !reset), uidx = upd_pc[IDX_W-1:0]:
  - Hit & taken: cnt = min(cnt+1, 3); target = upd_target.
  - Hit & not taken: cnt = max(cnt-1, 0); target unchanged; entry stays valid even at cnt 0.
  - Miss & taken: allocate/replace: valid=1, tag=upd_pc upper bits, target=upd_target, cnt=CNT_INIT.
  - Miss & not taken: no BTB change.
- upd_valid with upd_is_ctrl=0: no BTB or stat change.
- Stats, on clk when upd_valid & upd_is_ctrl:
  - stat_lookups += 1.
  - stat_mispredicts += upd_mispredict.
  - Each counter holds at 16'hFFFF.
- Same-cycle lookup and update of the same index:
  - Lookup returns the pre-update (old) contents; no bypass.
  - The new value is visible from the next cycle.
- Reset:
  - Takes priority over a concurrent update.
  - Next cycle: all valid=0, all cnt=0, stats=0.
  - pred_taken=0 and pred_next_pc=pc+1 from the first cycle after reset.
  - Tag/target contents need not be cleared.
- Reset asserted mid-training discards that cycle's update entirely.
- Stall handling is not the predictor's concern: the PC holds, so the lookup result is stable. The resolving stage must pulse upd_valid only once per instruction.
- Latency: prediction 0 cycles (combinational); training visible 1 cycle after the update edge.

Test Plan:
- Reset, then pc=16'h0010 -> pred_taken=0, pred_next_pc=16'h0011, stats=0.
- Update pc=16'h0010, taken, target=16'h0040, mispredict=1; next cycle pc=16'h0010 -> pred_taken=1, pred_next_pc=16'h0040, stat_lookups=1, stat_mispredicts=1.
- Saturation sequence on 16'h0010:
  - Two more taken updates, then not-taken -> cnt 3→2, still predicts taken.
  - A second not-taken -> cnt=1, pred_next_pc=16'h0011.
  - Three further not-takens -> cnt stays 0, entry valid.
- Aliasing: pc=16'h0020 (same idx 0, different tag) -> miss, pred_next_pc=16'h0021.
  - Then a taken update at 16'h0020 -> 16'h0100 replaces the entry.
  - Afterwards 16'h0010 misses.
- Same cycle: pc=16'h0030 lookup while updating 16'h0030 taken -> that cycle shows old (miss) result; next cycle pred_next_pc=target.
- Wrap and priority:
  - pc=16'hFFFF on a miss -> pred_next_pc=16'h0000.
  - reset asserted together with an update -> no entry allocated, stats remain 0.
